uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit; optional even parity.
- Deserialises the board's incoming serial line into bytes for the core's peripheral bus.
- Companion to the existing transmitter. Same baud arithmetic: 100 MHz clock, 9600 baud, 10416 clocks per bit.
- Holds each received byte until the consumer acknowledges it, and flags overrun and framing errors.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per bit period (100 MHz / 9600). Legal range is 8 or more.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the detected start edge to the mid-start-bit sample.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- uart_txd_in  in  1  serial line from the host. Asynchronous to clk; idles high.
- rx_data  out  8  last received byte. Stable while rx_valid is high.
- rx_valid  out  1  byte available. Level signal, held until rx_ack.
- rx_ack  in  1  consumer has taken rx_data. Sampled only while rx_valid=1.
- overrun  out  1  sticky: a byte completed while rx_valid was already high
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 without UART_RX_PARITY_EN.
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous and active-low (rst_n=0). All outputs go low and rx_data=0x00. The synchroniser flops reset to 1. FSM enters IDLE and the counters clear.
- An rst_n assertion mid-frame aborts the frame with no output pulses. Reception after release needs a fresh falling edge.
- Input path: uart_txd_in passes through a 2-flop synchroniser to give rxd_s. All sampling uses rxd_s.
- Bit timer: counter of width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, then wraps and raises a one-cycle tick.
- FSM states:
  - IDLE: bit timer held at 0. rxd_s=0 moves to START.
  - START: count HALF_BIT-1 cycles, then sample rxd_s.
    - If 1: false start (glitch); return to IDLE, no pulses.
    - If 0: restart the timer and go to DATA with bit index 0.
  - DATA: on each tick, shift rxd_s into a shift register at bit[index] (LSB first). After index 7, go to PARITY if the macro is enabled, else STOP.
  - PARITY: on tick, sample the parity bit and compare (see Optional Feature). Go to STOP.
  - STOP: on tick, sample rxd_s.
    - If 1: commit the frame. rx_data <= shift register; rx_valid <= 1.
    - If 0: frame_err pulses for 1 cycle, the byte is discarded, and the FSM goes to BREAK.
  - BREAK: wait for rxd_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- After a good stop sample the FSM returns to IDLE in the same cycle as the commit. It can therefore detect the next start edge in the following cycle, mid-stop-bit.
- Latency: rx_valid rises 1 clk after the mid-stop-bit sample, about 9.5 bit periods plus 3 clk after the start edge reaches the pin (10.5 bit periods with parity).
- Handshake:
  - rx_ack=1 while rx_valid=1 clears rx_valid and overrun on the next edge.
  - rx_ack while rx_valid=0 is ignored.
- Overrun:
  - Commit while rx_valid=1 and no rx_ack that cycle: rx_data is overwritten with the new byte, rx_valid stays 1, overrun is set.
  - Commit in the same cycle as rx_ack: the new byte wins. rx_valid stays 1 and overrun stays 0.
- Frame or parity error while rx_valid=1: rx_data and rx_valid are unchanged.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame carries an even parity bit between data bit 7 and the stop bit, and the PARITY state is present. On mismatch, parity_err pulses for 1 cycle, coincident with the stop-bit sample. The byte is not committed, and the stop bit is still checked, so frame_err can pulse in the same cycle.
- Undefined: no PARITY state, parity_err is constant 0, and the frame is 10 bits.

Test Plan:
1. CLKS_PER_BIT=16. Send 0xA5, good stop → rx_valid rises 1 clk after the mid-stop sample with rx_data=0xA5; frame_err=0, overrun=0. Pulse rx_ack → rx_valid=0 the next cycle.
2. Send 0x3C, do not ack, then send 0x7E → rx_data=0x7E, rx_valid=1, overrun=1. rx_ack clears both.
3. Send 0x55 with the stop bit driven 0, and hold the line low for 3 bit periods → one frame_err pulse, rx_valid stays 0, busy stays high until the line returns high, then a following 0x0F is received correctly.
4. Drive a 4-clk low glitch on an idle line → FSM returns to IDLE at the mid-start sample; no rx_valid, no frame_err.
5. Assert rst_n=0 during data bit 4 of 0xFF → all outputs go 0 immediately. After release, a full 0x81 frame gives rx_data=0x81.
6. With UART_RX_PARITY_EN defined: send 0x03 with parity bit 1 (wrong) → parity_err pulses once, rx_valid=0. Resend with parity bit 0 → rx_data=0x03, rx_valid=1.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- UART receiver, 8 data bits LSB first, 1 start bit, 1 stop bit.
//
// Build option: define UART_RX_PARITY_EN to expect an even parity bit
// between data bit 7 and the stop bit. Without it the frame is 10 bits and
// parity_err is constant 0.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   uart_txd_in  serial line from the host (asynchronous, idles high)
//   rx_data      last received byte, stable while rx_valid is high
//   rx_valid     byte available, held until rx_ack
//   rx_ack       consumer has taken rx_data (ignored while rx_valid=0)
//   overrun      sticky: a byte completed while rx_valid was already high
//   frame_err    one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: even-parity mismatch
//   busy         receiver is not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_txd_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_reg, state_next;
    logic             sync1_reg;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             overrun_reg, overrun_next;
    logic             frame_err_reg, frame_err_next;
    logic             tick;
    logic             par_bad;
    logic             commit;

`ifdef UART_RX_PARITY_EN
    logic par_bit_reg, par_bit_next;
    logic parity_err_reg, parity_err_next;
    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign par_bad    = (^shift_reg) ^ par_bit_reg;
    assign parity_err = parity_err_reg;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign tick      = (cnt_reg == CNT_LAST);
    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg      <= 1'b1;
            rxd_s          <= 1'b1;
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            sync1_reg      <= uart_txd_in;
            rxd_s          <= sync1_reg;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            data_reg       <= data_next;
            valid_reg      <= valid_next;
            overrun_reg    <= overrun_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg    <= par_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        overrun_next   = overrun_reg;
        frame_err_next = 1'b0;
        commit         = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next    = par_bit_reg;
        parity_err_next = 1'b0;
`endif

        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!rxd_s) state_next = S_START;
            end
            S_START: begin
                // Half a bit in: a line back high means a glitch, not a start.
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next   = S_DATA;
                        bit_idx_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DATA: begin
                cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
                if (tick) begin
                    shift_next[bit_idx_reg] = rxd_s;
                    bit_idx_next            = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
                if (tick) begin
                    par_bit_next = rxd_s;
                    state_next   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
                if (tick) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_next = par_bad;
`endif
                    if (rxd_s) begin
                        // Back to IDLE immediately so a start bit that begins
                        // mid-stop-bit is still caught.
                        commit     = !par_bad;
                        state_next = S_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low must go high before a new frame can start.
                cnt_next = '0;
                if (rxd_s) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (valid_reg && rx_ack) begin
            valid_next   = 1'b0;
            overrun_next = 1'b0;
        end
        // A commit in the same cycle as an ack replaces the acked byte cleanly.
        if (commit) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            if (valid_reg && !rx_ack) overrun_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Start edge on the pin to the commit edge: 2 sync flops + 1 detect,
    // half a bit, then data (+parity) bits to the middle of the stop bit.
    localparam int STOP_EDGE = 3 + HALF + NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       txd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_txd_in(txd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts high cycles of the error pulses and records
    // the cycle at which rx_valid rises.
    int   ferr_cnt = 0;
    int   perr_cnt = 0;
    int   rise_cyc = -1;
    logic valid_q  = 1'b0;
    always @(negedge clk) begin
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (rx_valid && !valid_q) rise_cyc = cyc;
        valid_q = rx_valid;
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the consumer-visible state after whole frames.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovr   = 1'b0;

    task automatic model_frame(input logic [7:0] d, input logic stop, input logic pgood);
        if (stop && pgood) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = d;
        end
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        txd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives start, data, optional parity and stop; leaves the line at the stop level.
    task automatic send_bits(input logic [7:0] d, input logic stop, input logic pgood);
        txd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            txd = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        txd = (^d) ^ ~pgood;
        repeat (CPB) @(negedge clk);
`endif
        txd = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pgood);
        send_bits(d, stop, pgood);
        txd = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int f0, input int p0,
                               input logic stop, input logic pgood);
        check({tag, "_valid"}, rx_valid, m_valid);
        check({tag, "_data"}, rx_data, m_data);
        check({tag, "_ovr"}, overrun, m_ovr);
        check({tag, "_ferr"}, ferr_cnt - f0, stop ? 0 : 1);
`ifdef UART_RX_PARITY_EN
        check({tag, "_perr"}, perr_cnt - p0, pgood ? 0 : 1);
`else
        check({tag, "_perr"}, perr_cnt - p0, 0);
`endif
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_before;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ovr;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int   f0, p0, c0;
        logic [7:0] d;
        logic stop, pgood, was_valid;

        tbl[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 0};
        tbl[1] = '{8'h7E, 1'b1, 1'b0, 1'b1, 8'h7E, 1'b1, 0};
        tbl[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b0, 1};
        tbl[3] = '{8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 0};
        tbl[4] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1};
        tbl[5] = '{8'h96, 1'b1, 1'b1, 1'b1, 8'h96, 1'b0, 0};

        rst_n  = 1'b0;
        txd    = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ovr", overrun, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(4);

        // Basic byte, exact commit latency, then ack clears on the next edge.
        c0 = cyc; f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b1);
        check("t1_latency", rise_cyc, c0 + STOP_EDGE);
        check_frame("t1", f0, p0, 1'b1, 1'b1);
        do_ack();
        check("t1_ack_clear", rx_valid, 0);
        idle(4);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].ack_before) begin
                do_ack();
                check($sformatf("tbl%0d_ack_valid", i), rx_valid, 0);
                check($sformatf("tbl%0d_ack_ovr", i), overrun, 0);
            end
            idle(4);
            f0 = ferr_cnt;
            send_frame(tbl[i].data, tbl[i].stop, 1'b1);
            model_frame(tbl[i].data, tbl[i].stop, 1'b1);
            check($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].exp_valid);
            check($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_data);
            check($sformatf("tbl%0d_ovr", i), overrun, tbl[i].exp_ovr);
            check($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
        end

        // Bad stop with the line held low: stay busy until it goes high.
        do_ack();
        idle(4);
        f0 = ferr_cnt;
        send_bits(8'h55, 1'b0, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        check("brk_busy_low", busy, 1);
        check("brk_ferr", ferr_cnt - f0, 1);
        check("brk_valid", rx_valid, 0);
        idle(5);
        check("brk_busy_released", busy, 0);
        f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h0F, 1'b1, 1'b1);
        model_frame(8'h0F, 1'b1, 1'b1);
        check_frame("brk_next", f0, p0, 1'b1, 1'b1);
        idle(4);

        // Short low glitch is rejected at the mid-start sample.
        f0 = ferr_cnt;
        txd = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", busy, 1);
        idle(20);
        check("glitch_idle", busy, 0);
        check("glitch_valid", rx_valid, m_valid);
        check("glitch_data", rx_data, m_data);
        check("glitch_ferr", ferr_cnt - f0, 0);

        // Overrun, then a commit in the same cycle as ack: new byte wins.
        send_frame(8'h11, 1'b1, 1'b1);
        model_frame(8'h11, 1'b1, 1'b1);
        check("ovr_set", overrun, 1);
        idle(4);
        c0 = cyc;
        fork
            send_frame(8'hE7, 1'b1, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        m_valid = 1'b1; m_data = 8'hE7; m_ovr = 1'b0;
        check("ackcommit_valid", rx_valid, 1);
        check("ackcommit_data", rx_data, 8'hE7);
        check("ackcommit_ovr", overrun, 0);
        idle(4);

        // Reset during data bit 4 of 0xFF aborts everything at once.
        f0 = ferr_cnt;
        txd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            txd = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", rx_valid, 0);
        check("arst_data", rx_data, 0);
        check("arst_ovr", overrun, 0);
        check("arst_busy", busy, 0);
        m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        check("arst_idle_busy", busy, 0);
        check("arst_ferr", ferr_cnt - f0, 0);
        f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h81, 1'b1, 1'b1);
        model_frame(8'h81, 1'b1, 1'b1);
        check_frame("arst_next", f0, p0, 1'b1, 1'b1);
        do_ack();
        idle(4);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit is rejected, the correct one accepted.
        f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h03, 1'b1, 1'b0);
        model_frame(8'h03, 1'b1, 1'b0);
        check_frame("par_bad", f0, p0, 1'b1, 1'b0);
        idle(4);
        f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h03, 1'b1, 1'b1);
        model_frame(8'h03, 1'b1, 1'b1);
        check_frame("par_good", f0, p0, 1'b1, 1'b1);
        do_ack();
        idle(4);
`endif

        // Random frames against the model.
        for (int n = 0; n < 24; n++) begin
            d     = 8'($urandom);
            stop  = ($urandom_range(0, 7) != 0);
            pgood = 1'b1;
`ifdef UART_RX_PARITY_EN
            pgood = ($urandom_range(0, 5) != 0);
`endif
            if ($urandom_range(0, 2) == 0) do_ack();
            idle($urandom_range(4, 30));
            was_valid = m_valid;
            c0 = cyc; f0 = ferr_cnt; p0 = perr_cnt;
            send_frame(d, stop, pgood);
            model_frame(d, stop, pgood);
            check_frame($sformatf("rnd%0d", n), f0, p0, stop, pgood);
            if (stop && pgood && !was_valid)
                check($sformatf("rnd%0d_latency", n), rise_cyc, c0 + STOP_EDGE);
        end

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
